// File: rtl/c64_bus_pkg.sv
// c64_bus_pkg: shared types and constants for the C64 bus responder.
//   - region_e : what an address currently maps to for a CPU read
//   - state_e  : responder FSM (RAM fill, then normal running)
//   - region base addresses, processor-port reset defaults, rom_sel codes
//   - rom_sel_of(): region -> rom_sel encoding
package c64_bus_pkg;

  typedef enum logic [2:0] {
    REG_RAM    = 3'd0,
    REG_BASIC  = 3'd1,
    REG_KERNAL = 3'd2,
    REG_CHAR   = 3'd3,
    REG_IO     = 3'd4,
    REG_PORT   = 3'd5
  } region_e;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [15:0] BASIC_BASE   = 16'hA000;
  localparam logic [15:0] IO_CHAR_BASE = 16'hD000;
  localparam logic [15:0] KERNAL_BASE  = 16'hE000;

  localparam logic [7:0] C64_DDR_RST  = 8'h2F;
  localparam logic [7:0] C64_PORT_RST = 8'h37;

  localparam logic [1:0] ROM_NONE   = 2'd0;
  localparam logic [1:0] ROM_BASIC  = 2'd1;
  localparam logic [1:0] ROM_KERNAL = 2'd2;
  localparam logic [1:0] ROM_CHAR   = 2'd3;

  // ROM port selection for a decoded region; non-ROM regions select nothing.
  function automatic logic [1:0] rom_sel_of(input region_e r);
    logic [1:0] sel;
    case (r)
      REG_BASIC:  sel = ROM_BASIC;
      REG_KERNAL: sel = ROM_KERNAL;
      REG_CHAR:   sel = ROM_CHAR;
      default:    sel = ROM_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/c64_bus_responder_if.sv
// c64_bus_responder_if: the 6502 core's memory bus.
//   ab     : CPU address
//   cpu_do : CPU write data (the core's "do" output)
//   we     : CPU write enable, active high
//   di     : read data returned to the CPU
// master = CPU side, slave = memory responder side.
interface c64_bus_responder_if;
  logic [15:0] ab;
  logic [7:0]  cpu_do;
  logic        we;
  logic [7:0]  di;

  modport master (output ab, output cpu_do, output we, input di);
  modport slave  (input ab, input cpu_do, input we, output di);
endinterface

// File: rtl/c64_bus_responder_bank_decode.sv
// c64_bank_decode: purely combinational C64 read-region decode.
//   ab_i     : CPU address
//   eff_i    : effective processor-port bits {CHAREN, HIRAM, LORAM}
//   region_o : region the address maps to
// Macro PROC_PORT_EN: when defined, $0000/$0001 decode as the processor port;
// otherwise they are ordinary RAM.
module c64_bank_decode
  import c64_bus_pkg::*;
(
  input  logic [15:0] ab_i,
  input  logic [2:0]  eff_i,
  output region_e     region_o
);

  logic loram_s;
  logic hiram_s;
  logic charen_s;

  assign loram_s  = eff_i[0];
  assign hiram_s  = eff_i[1];
  assign charen_s = eff_i[2];

  // Address/banking to region; anything not claimed falls through to RAM.
  always_comb begin
    region_o = REG_RAM;
`ifdef PROC_PORT_EN
    if (ab_i[15:1] == 15'h0000) begin
      region_o = REG_PORT;
    end else
`endif
    if (ab_i[15:13] == BASIC_BASE[15:13]) begin
      if (loram_s && hiram_s) region_o = REG_BASIC;
      else                    region_o = REG_RAM;
    end else if (ab_i[15:13] == KERNAL_BASE[15:13]) begin
      if (hiram_s) region_o = REG_KERNAL;
      else         region_o = REG_RAM;
    end else if (ab_i[15:12] == IO_CHAR_BASE[15:12]) begin
      // $Dxxx is RAM only when both LORAM and HIRAM are low.
      if (loram_s || hiram_s) region_o = charen_s ? REG_IO : REG_CHAR;
      else                    region_o = REG_RAM;
    end else begin
      region_o = REG_RAM;
    end
  end

endmodule

// File: rtl/c64_bus_responder.sv
// c64_bus_responder: memory-side responder for the 6502 core's bus.
// Holds main RAM (2^RAM_AW bytes, mirrored across the 64K map), the $00/$01
// processor port, and routes reads/writes per C64 banking. After reset it
// fills RAM with INIT_PATTERN, holding the CPU in reset until done.
// Ports:
//   clk, reset     : clock, synchronous active-low reset
//   bus            : CPU bus (ab, cpu_do, we in; di out), slave modport
//   cpu_reset_o    : active-high CPU reset, 1 during reset and fill
//   rom_sel_o      : 0 none, 1 BASIC, 2 KERNAL, 3 CHAR
//   rom_addr_o     : ab[12:0];  rom_data_i : ROM read data
//   io_sel_o, io_we_o, io_addr_o (ab[11:0]), io_wdata_o, io_rdata_i : I/O port
//   port_out_o     : effective processor-port pins
// Macro PROC_PORT_EN: enables the DDR/data port registers and dynamic banking.
// Without it the port is fixed at 8'h37 and $0000/$0001 are plain RAM.
module c64_bus_responder
  import c64_bus_pkg::*;
#(
  parameter int          RAM_AW       = 16,
  parameter logic [7:0]  INIT_PATTERN = 8'h00,
  parameter logic [7:0]  DDR_RST      = C64_DDR_RST,
  parameter logic [7:0]  PORT_RST     = C64_PORT_RST
) (
  input  logic                 clk,
  input  logic                 reset,
  c64_bus_responder_if.slave   bus,
  output logic                 cpu_reset_o,
  output logic [1:0]           rom_sel_o,
  output logic [12:0]          rom_addr_o,
  input  logic [7:0]           rom_data_i,
  output logic                 io_sel_o,
  output logic                 io_we_o,
  output logic [11:0]          io_addr_o,
  output logic [7:0]           io_wdata_o,
  input  logic [7:0]           io_rdata_i,
  output logic [7:0]           port_out_o
);

  localparam logic [RAM_AW-1:0] CNT_LAST = {RAM_AW{1'b1}};
  localparam logic [RAM_AW-1:0] CNT_ONE  = {{(RAM_AW-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [RAM_AW-1:0] cnt_q, cnt_d;
  logic [7:0]        mem [2**RAM_AW];

  logic              run_s;
  logic [7:0]        eff_s;
  region_e           region_s;
  logic [RAM_AW-1:0] ram_idx_s;
  logic [7:0]        ram_rdata_s;
  logic              ram_we_s;
  logic [RAM_AW-1:0] ram_waddr_s;
  logic [7:0]        ram_wdata_s;

  assign run_s       = (state_q == ST_RUN);
  assign ram_idx_s   = bus.ab[RAM_AW-1:0];
  assign ram_rdata_s = mem[ram_idx_s];

  c64_bank_decode u_decode (
    .ab_i     (bus.ab),
    .eff_i    (eff_s[2:0]),
    .region_o (region_s)
  );

  // FSM state and fill counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: FILL walks every RAM address once, then RUN until reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_FILL: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = ST_RUN;
        else                   state_d = ST_FILL;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_FILL;
    endcase
  end

  // RAM write port: fill pattern in FILL, CPU writes in RUN except to I/O.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = ram_idx_s;
    ram_wdata_s = bus.cpu_do;
    if (!reset) begin
      ram_we_s = 1'b0;
    end else if (!run_s) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = cnt_q;
      ram_wdata_s = INIT_PATTERN;
    end else begin
      ram_we_s = bus.we && (region_s != REG_IO);
    end
  end

  // RAM storage; not reset, the fill sequence initialises it.
  always_ff @(posedge clk) begin
    if (ram_we_s) mem[ram_waddr_s] <= ram_wdata_s;
  end

`ifdef PROC_PORT_EN
  logic [7:0] ddr_q, ddr_d;
  logic [7:0] pdata_q, pdata_d;

  // Processor-port DDR and data registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ddr_q   <= DDR_RST;
      pdata_q <= PORT_RST;
    end else begin
      ddr_q   <= ddr_d;
      pdata_q <= pdata_d;
    end
  end

  // CPU writes to $0000/$0001 load the port (the RAM copy is written too).
  always_comb begin
    ddr_d   = ddr_q;
    pdata_d = pdata_q;
    if (run_s && bus.we && (bus.ab == 16'h0000)) begin
      ddr_d = bus.cpu_do;
    end else if (run_s && bus.we && (bus.ab == 16'h0001)) begin
      pdata_d = bus.cpu_do;
    end else begin
      ddr_d   = ddr_q;
      pdata_d = pdata_q;
    end
  end

  // Input-direction bits read as 1 through the pull-ups.
  assign eff_s = (ddr_q & pdata_q) | ~ddr_q;
`else
  assign eff_s = 8'h37;
`endif

  // Read mux; a ROM-visible address reads the ROM even while RAM is written.
  always_comb begin
    bus.di = 8'h00;
    if (!run_s) begin
      bus.di = 8'h00;
    end else begin
      case (region_s)
        REG_BASIC, REG_KERNAL, REG_CHAR: bus.di = rom_data_i;
        REG_IO:                          bus.di = io_rdata_i;
`ifdef PROC_PORT_EN
        REG_PORT:                        bus.di = bus.ab[0] ? eff_s : ddr_q;
`endif
        default:                         bus.di = ram_rdata_s;
      endcase
    end
  end

  // Peripheral-side outputs; selects and strobes are suppressed during fill.
  always_comb begin
    cpu_reset_o = !reset || !run_s;
    rom_sel_o   = ROM_NONE;
    io_sel_o    = 1'b0;
    if (run_s) begin
      rom_sel_o = rom_sel_of(region_s);
      io_sel_o  = (region_s == REG_IO);
    end else begin
      rom_sel_o = ROM_NONE;
      io_sel_o  = 1'b0;
    end
    io_we_o    = io_sel_o && bus.we;
    rom_addr_o = bus.ab[12:0];
    io_addr_o  = bus.ab[11:0];
    io_wdata_o = bus.cpu_do;
    port_out_o = eff_s;
  end

endmodule

// File: tb/tb_c64_bus_responder.sv
// Scoreboard bench for c64_bus_responder (RAM_AW=8, INIT_PATTERN=A5).
// Stimulus drives the bus after each posedge and queues expected values;
// the monitor compares them against the DUT on the following negedge.
module tb_c64_bus_responder;

  logic        clk;
  logic        reset;
  logic        cpu_reset;
  logic [1:0]  rom_sel;
  logic [12:0] rom_addr;
  logic [7:0]  rom_data;
  logic        io_sel;
  logic        io_we;
  logic [11:0] io_addr;
  logic [7:0]  io_wdata;
  logic [7:0]  io_rdata;
  logic [7:0]  port_out;

  int checks = 0;
  int errors = 0;

  string       name_q[$];
  int          field_q[$];
  logic [15:0] val_q[$];

`ifdef PROC_PORT_EN
  localparam logic [7:0] EFF_DEF = 8'hF7;
`else
  localparam logic [7:0] EFF_DEF = 8'h37;
`endif

  c64_bus_responder_if bus ();

  c64_bus_responder #(.RAM_AW(8), .INIT_PATTERN(8'hA5)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .cpu_reset_o (cpu_reset),
    .rom_sel_o   (rom_sel),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data),
    .io_sel_o    (io_sel),
    .io_we_o     (io_we),
    .io_addr_o   (io_addr),
    .io_wdata_o  (io_wdata),
    .io_rdata_i  (io_rdata),
    .port_out_o  (port_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: one constant byte per ROM so the selected ROM is visible on di.
  always_comb begin
    case (rom_sel)
      2'd1:    rom_data = 8'hBA;
      2'd2:    rom_data = 8'hCE;
      2'd3:    rom_data = 8'hC4;
      default: rom_data = 8'h00;
    endcase
  end
  assign io_rdata = 8'h1D;

  localparam int F_DI = 0, F_CPURST = 1, F_ROMSEL = 2, F_IOSEL = 3, F_IOWE = 4,
                 F_IOWDATA = 5, F_PORT = 6, F_IOADDR = 7;

  function automatic logic [15:0] field_val(input int f);
    case (f)
      F_DI:      return {8'h00, bus.di};
      F_CPURST:  return {15'h0000, cpu_reset};
      F_ROMSEL:  return {14'h0000, rom_sel};
      F_IOSEL:   return {15'h0000, io_sel};
      F_IOWE:    return {15'h0000, io_we};
      F_IOWDATA: return {8'h00, io_wdata};
      F_PORT:    return {8'h00, port_out};
      F_IOADDR:  return {4'h0, io_addr};
      default:   return 16'hDEAD;
    endcase
  endfunction

  // Monitor: compare everything queued for this cycle.
  always @(negedge clk) begin
    string       n;
    int          f;
    logic [15:0] v;
    logic [15:0] act;
    while (name_q.size() > 0) begin
      n   = name_q.pop_front();
      f   = field_q.pop_front();
      v   = val_q.pop_front();
      act = field_val(f);
      checks++;
      if (act !== v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", n, act, v);
      end
    end
  end

  task automatic expect_f(input string n, input int f, input logic [15:0] v);
    name_q.push_back(n);
    field_q.push_back(f);
    val_q.push_back(v);
  endtask

  task automatic drive(input logic [15:0] a, input logic w, input logic [7:0] d);
    bus.ab     = a;
    bus.we     = w;
    bus.cpu_do = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fill window: cpu_reset must stay 1 for n cycles; bus held with a write.
  task automatic fill_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      drive((i < 128) ? 16'hD020 : 16'h0030, 1'b1, 8'h77);
      expect_f({tag, "_cpurst"}, F_CPURST, 16'd1);
      expect_f({tag, "_di"}, F_DI, 16'h0000);
      expect_f({tag, "_iosel"}, F_IOSEL, 16'd0);
      expect_f({tag, "_iowe"}, F_IOWE, 16'd0);
      step();
    end
    drive(16'h0010, 1'b0, 8'h00);
  endtask

  task automatic rd(input string n, input logic [15:0] a, input logic [7:0] d);
    drive(a, 1'b0, 8'h00);
    expect_f(n, F_DI, {8'h00, d});
    step();
  endtask

  initial begin
    reset = 1'b0;
    drive(16'h0000, 1'b0, 8'h00);
    step();
    expect_f("rst_cpurst", F_CPURST, 16'd1);
    step();
    expect_f("rst_cpurst", F_CPURST, 16'd1);
    expect_f("rst_port", F_PORT, {8'h00, EFF_DEF});
    step();
    reset = 1'b1;

    fill_cycles(256, "fill1");
    expect_f("run_cpurst", F_CPURST, 16'd0);
    rd("rd_0010", 16'h0010, 8'hA5);
    rd("rd_0110_mirror", 16'h0110, 8'hA5);

    // RAM under BASIC: write lands in RAM, read still sees ROM.
    drive(16'hA000, 1'b1, 8'h42);
    expect_f("wr_a000_romsel", F_ROMSEL, 16'd1);
    expect_f("wr_a000_di", F_DI, 16'h00BA);
    step();
    drive(16'hA000, 1'b0, 8'h00);
    expect_f("rd_a000_romsel", F_ROMSEL, 16'd1);
    expect_f("rd_a000_di", F_DI, 16'h00BA);
    step();

`ifdef PROC_PORT_EN
    drive(16'h0001, 1'b1, 8'h36);
    step();
    drive(16'hA000, 1'b0, 8'h00);
    expect_f("bank36_romsel", F_ROMSEL, 16'd0);
    expect_f("bank36_di", F_DI, 16'h0042);
    expect_f("bank36_port", F_PORT, 16'h00F6);
    step();
    drive(16'h0001, 1'b1, 8'h37);
    step();
`endif

    drive(16'hD020, 1'b0, 8'h00);
    expect_f("rd_d020_iosel", F_IOSEL, 16'd1);
    expect_f("rd_d020_di", F_DI, 16'h001D);
    expect_f("rd_d020_ioaddr", F_IOADDR, 16'h0020);
    expect_f("rd_d020_iowe", F_IOWE, 16'd0);
    step();
    drive(16'hD020, 1'b1, 8'h07);
    expect_f("wr_d020_iowe", F_IOWE, 16'd1);
    expect_f("wr_d020_wdata", F_IOWDATA, 16'h0007);
    step();
    drive(16'hD020, 1'b0, 8'h00);
    expect_f("after_d020_iowe", F_IOWE, 16'd0);
    step();
    rd("ram_d020_untouched", 16'h0020, 8'hA5);

`ifdef PROC_PORT_EN
    drive(16'h0001, 1'b1, 8'h33);
    step();
    drive(16'hD020, 1'b0, 8'h00);
    expect_f("char_romsel", F_ROMSEL, 16'd3);
    expect_f("char_di", F_DI, 16'h00C4);
    expect_f("char_iosel", F_IOSEL, 16'd0);
    step();
    drive(16'h0000, 1'b1, 8'h00);
    step();
    expect_f("ddr0_port", F_PORT, 16'h00FF);
    rd("rd_ddr", 16'h0000, 8'h00);
    rd("rd_eff", 16'h0001, 8'hFF);
    drive(16'hE000, 1'b0, 8'h00);
    expect_f("ddr0_kernal", F_ROMSEL, 16'd2);
    step();
`else
    drive(16'h0001, 1'b1, 8'h00);
    step();
    drive(16'hE000, 1'b0, 8'h00);
    expect_f("fixed_kernal_romsel", F_ROMSEL, 16'd2);
    expect_f("fixed_kernal_di", F_DI, 16'h00CE);
    expect_f("fixed_port", F_PORT, 16'h0037);
    step();
    rd("ram_0001", 16'h0001, 8'h00);
    drive(16'h0000, 1'b1, 8'h5A);
    step();
    rd("ram_0000", 16'h0000, 8'h5A);
`endif

    drive(16'h0050, 1'b1, 8'h11);
    step();
    rd("rd_0050", 16'h0050, 8'h11);

    // Reset in RUN, then again 100 cycles into the fill.
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    fill_cycles(100, "fill2");
    reset = 1'b0;
    expect_f("midfill_rst_cpurst", F_CPURST, 16'd1);
    step();
    reset = 1'b1;
    fill_cycles(256, "fill3");
    expect_f("run2_cpurst", F_CPURST, 16'd0);
    expect_f("run2_port", F_PORT, {8'h00, EFF_DEF});
    rd("refill_0030", 16'h0030, 8'hA5);
    rd("refill_0050", 16'h0050, 8'hA5);
`ifdef PROC_PORT_EN
    rd("rst_ddr", 16'h0000, 8'h2F);
    rd("rst_eff", 16'h0001, 8'hF7);
`else
    rd("refill_0000", 16'h0000, 8'hA5);
    rd("refill_0001", 16'h0001, 8'hA5);
`endif

    step();
    step();
    if (name_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", name_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/c64_bus_responder.md
Name: c64_bus_responder

Overview:
- Memory-side responder for the 6502 core's bus (ab, do, we in; di out).
- Holds main RAM and the $00/$01 processor port, and applies C64 banking.
- Routes reads to RAM, BASIC/KERNAL/CHAR ROM ports or the I/O port, and routes writes to RAM or I/O.
- After reset it clears RAM with a fill sequence, holding the CPU in reset until the fill completes.

Parameters:
- RAM_AW, 16: RAM address width. RAM size is 2^RAM_AW; RAM is indexed by ab[RAM_AW-1:0], so higher addresses mirror.
- INIT_PATTERN, 8'h00: byte written to every RAM location during the fill.
- DDR_RST, 8'h2F: processor-port DDR reset value.
- PORT_RST, 8'h37: processor-port data reset value.

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-low reset
- ab  in  16  CPU address
- do  in  8  CPU write data
- we  in  1  CPU write enable, active high
- di  out  8  CPU read data, combinational from ab
- cpu_reset  out  1  active-high reset to the CPU; 1 during reset and fill
- rom_sel  out  2  0 none, 1 BASIC, 2 KERNAL, 3 CHAR
- rom_addr  out  13  ab[12:0]
- rom_data  in  8  ROM read data, combinational
- io_sel  out  1  I/O region addressed
- io_we  out  1  I/O write strobe, equal to io_sel & we while running
- io_addr  out  12  ab[11:0]
- io_wdata  out  8  equal to do
- io_rdata  in  8  I/O read data
- port_out  out  8  effective port pins

Behaviour:
- Reset (reset==0 at posedge):
  - state<=FILL, fill counter<=0, ddr<=DDR_RST, pdata<=PORT_RST.
  - cpu_reset is 1. Reset asserted mid-fill restarts the fill from address 0.
- FSM states: FILL and RUN.
  - FILL: writes INIT_PATTERN to RAM[cnt] each cycle and increments cnt. After the cycle that writes cnt==2^RAM_AW-1, state goes to RUN.
  - RUN: cpu_reset<=0. RUN has no exit except reset.
  - Fill takes exactly 2^RAM_AW cycles.
  - In FILL, CPU we is ignored; io_we=0 and io_sel=0.
- Effective port bits: eff[i] = ddr[i] ? pdata[i] : 1 (pull-up). port_out=eff. LORAM=eff[0], HIRAM=eff[1], CHAREN=eff[2].
- Read region decode:
  - $A000-$BFFF: BASIC if LORAM&HIRAM.
  - $E000-$FFFF: KERNAL if HIRAM.
  - $D000-$DFFF: if LORAM|HIRAM, then CHAREN ? I/O : CHAR; otherwise RAM.
  - $0000 reads DDR; $0001 reads eff.
  - Everything else reads RAM.
- Writes (RUN, we==1, committed at posedge):
  - I/O region: io_we only; RAM is not written.
  - Every other address writes RAM[ab], including ROM-shadowed areas (RAM under ROM).
  - $0000 also loads ddr; $0001 also loads pdata.
- Latency: reads are combinational. A write at edge N is visible on di for the same ab in the cycle after edge N. Banking changes take effect on the cycle after the $00/$01 write.
- Simultaneous ROM-visible read and write to the same address: di shows ROM, and RAM receives the write.
- di in FILL: 8'h00.

Optional Feature:
- Macro: PROC_PORT_EN.
- Defined: processor port and dynamic banking as above.
- Undefined:
  - No ddr/pdata registers; eff is fixed at 8'h37 and port_out=8'h37.
  - $0000/$0001 are plain RAM for both read and write.

Decomposition:
- Package c64_bus_pkg holds:
  - region enum: REG_RAM, REG_BASIC, REG_KERNAL, REG_CHAR, REG_IO, REG_PORT
  - region base constants: $A000, $D000, $E000
  - DDR_RST and PORT_RST defaults
  - rom_sel encodings
- Sub-module c64_bank_decode: purely combinational (ab, eff[2:0]) -> region. This module holds RAM, port registers, fill FSM and muxes.

Test Plan:
- RAM_AW=8, INIT_PATTERN=8'hA5, reset low 3 cycles then high -> cpu_reset stays 1 for exactly 256 cycles, then 0; reading $0010 returns A5, and so does $0110 (mirror).
- RUN; write $42 to $A000; read $A000 -> rom_sel=1, di=rom_data. Write $0001<=$36, next cycle read $A000 -> di=$42, rom_sel=0.
- Read $D020 at default port -> io_sel=1, di=io_rdata. Write $D020<=$07 -> io_we=1 and io_wdata=$07 for one cycle, RAM[$D020] unchanged. Set $0001<=$33 -> $D020 read gives rom_sel=3.
- Write $0000<=$00 -> port_out=$FF regardless of pdata; read $0000 -> $00, read $0001 -> $FF.
- Reset asserted at fill count 100 -> count restarts at 0, ddr=$2F, pdata=$37, cpu_reset held for the full fill.
- PROC_PORT_EN undefined: write $0001<=$00 -> $E000 still reads KERNAL; $0001 reads back $00 from RAM.
